// File: rtl/uart_rx_frame.sv
// uart_rx_frame
// Receive-side UART deserializer running in the RX oversampling clock domain.
// Each bit is decided by a majority vote of three samples around its centre;
// an optional parity bit is checked, and one result per frame is reported
// through single-cycle strobes.
//
// Ports:
//   CLK            RX oversampling clock, rising edge
//   RST            asynchronous active-high reset
//   RX_IN          serial line (idle high), already synchronised to CLK
//   Prescale       oversampling ratio; 16 and 32 honoured, anything else means 8
//   PAR_EN         frame carries a parity bit
//   PAR_TYP        0 = even parity, 1 = odd parity
//   P_DATA         last cleanly received byte
//   data_valid     one-cycle pulse, P_DATA just updated
//   parity_error   one-cycle pulse, parity mismatch on the frame just ended
//   framing_error  one-cycle pulse, stop bit decided as 0

module uart_rx_frame #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    output logic [DATA_WIDTH-1:0]     P_DATA,
    output logic                      data_valid,
    output logic                      parity_error,
    output logic                      framing_error
);

    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DONE
    } rx_state_t;

    rx_state_t state;
    rx_state_t next_state;

    logic [5:0]            edge_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic [1:0]            ratio_sel;
    logic [1:0]            ratio_sel_in;
    logic                  par_en_lat;
    logic                  par_typ_lat;
    logic                  sample_a;
    logic                  sample_b;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  par_err_q;
    logic                  stop_err_q;

    logic [5:0] half;
    logic [5:0] last;
    logic       at_first_sample;
    logic       at_second_sample;
    logic       at_decide;
    logic       at_last;
    logic       bit_val;

    // Decode the ratio on the live input so it can be latched at start
    // detection, and derive the sample positions from the latched ratio.
    // The third sample is the live line value in the decision cycle, so the
    // majority is available without an extra register stage.
    always_comb begin
        ratio_sel_in = 2'd0;
        if (Prescale == PRESCALE_WIDTH'(16)) begin
            ratio_sel_in = 2'd1;
        end else if (Prescale == PRESCALE_WIDTH'(32)) begin
            ratio_sel_in = 2'd2;
        end

        case (ratio_sel)
            2'd1:    half = 6'd8;
            2'd2:    half = 6'd16;
            default: half = 6'd4;
        endcase
        last = half + half - 6'd1;

        at_first_sample  = (edge_cnt == half - 6'd1);
        at_second_sample = (edge_cnt == half);
        at_decide        = (edge_cnt == half + 6'd1);
        at_last          = (edge_cnt == last);

        bit_val = (sample_a & sample_b) | (sample_a & RX_IN) | (sample_b & RX_IN);
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. The stop bit is left at its decision point so a start
    // bit that follows it directly is still seen from IDLE, and a start bit
    // that votes high is treated as a glitch and dropped at once.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (!RX_IN) begin
                    next_state = START;
                end
            end
            START: begin
                if (at_decide && bit_val) begin
                    next_state = IDLE;
                end else if (at_last) begin
                    next_state = DATA;
                end
            end
            DATA: begin
                if (at_last && (bit_cnt == LAST_BIT)) begin
                    next_state = par_en_lat ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (at_last) begin
                    next_state = STOP;
                end
            end
            STOP: begin
                if (at_decide) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath: counters, configuration latch, bit samples, shift register,
    // error flags and the output registers. The start-detect cycle counts as
    // position 0 of the start bit, so the counter is loaded with 1 there.
    // Outputs only change in DONE; an erroneous frame leaves P_DATA alone.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            edge_cnt      <= '0;
            bit_cnt       <= '0;
            ratio_sel     <= 2'd0;
            par_en_lat    <= 1'b0;
            par_typ_lat   <= 1'b0;
            sample_a      <= 1'b1;
            sample_b      <= 1'b1;
            shift_reg     <= '0;
            par_err_q     <= 1'b0;
            stop_err_q    <= 1'b0;
            P_DATA        <= '0;
            data_valid    <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            data_valid    <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    if (!RX_IN) begin
                        edge_cnt    <= 6'd1;
                        ratio_sel   <= ratio_sel_in;
                        par_en_lat  <= PAR_EN;
                        par_typ_lat <= PAR_TYP;
                        par_err_q   <= 1'b0;
                        stop_err_q  <= 1'b0;
                    end else begin
                        edge_cnt <= '0;
                    end
                end
                DONE: begin
                    edge_cnt      <= '0;
                    parity_error  <= par_err_q;
                    framing_error <= stop_err_q;
                    if (!par_err_q && !stop_err_q) begin
                        P_DATA     <= shift_reg;
                        data_valid <= 1'b1;
                    end
                end
                default: begin
                    edge_cnt <= at_last ? 6'd0 : edge_cnt + 6'd1;
                    if (at_first_sample) begin
                        sample_a <= RX_IN;
                    end
                    if (at_second_sample) begin
                        sample_b <= RX_IN;
                    end
                    if (state == DATA) begin
                        if (at_decide) begin
                            shift_reg <= {bit_val, shift_reg[DATA_WIDTH-1:1]};
                        end
                        if (at_last) begin
                            bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + BIT_W'(1);
                        end
                    end
                    if ((state == PARITY) && at_decide) begin
                        par_err_q <= bit_val ^ (^shift_reg) ^ par_typ_lat;
                    end
                    if ((state == STOP) && at_decide) begin
                        stop_err_q <= ~bit_val;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame
// Drives serial frames into uart_rx_frame and compares every strobe against
// a queue of expected results (flags, byte and the edge at which it appears).

module tb_uart_rx_frame;

    logic       CLK;
    logic       RST;
    logic       RX_IN;
    logic [5:0] Prescale;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       parity_error;
    logic       framing_error;

    typedef struct {
        logic [2:0] flags;
        logic [7:0] data;
        int         edgeIdx;
    } expect_t;

    expect_t expQ[$];

    int         totalChecks = 0;
    int         badChecks   = 0;
    int         edgeCount   = 0;
    logic [7:0] lastGood    = 8'h00;

    uart_rx_frame #(
        .DATA_WIDTH(8),
        .PRESCALE_WIDTH(6)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .RX_IN(RX_IN),
        .Prescale(Prescale),
        .PAR_EN(PAR_EN),
        .PAR_TYP(PAR_TYP),
        .P_DATA(P_DATA),
        .data_valid(data_valid),
        .parity_error(parity_error),
        .framing_error(framing_error)
    );

    // 10 ns clock.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Free-running edge index; the value before the increment names the edge.
    always @(posedge CLK) edgeCount <= edgeCount + 1;

    // Hard time limit so the run always terminates.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Sends one frame: start, 8 data bits LSB first, optional parity, stop,
    // then idleAfter cycles of idle line. The configuration inputs are
    // scrambled after the start bit to show they are latched at start.
    task automatic applyStimulus(input logic [7:0] data, input logic [5:0] code,
                                 input int bitLen, input bit parEn, input bit parTyp,
                                 input bit badPar, input bit stopBit, input int idleAfter);
        logic [10:0] frameBits;
        logic        parBit;
        int          n;
        expect_t     e;
        logic        perr;
        logic        ferr;
        Prescale  = code;
        PAR_EN    = parEn;
        PAR_TYP   = parTyp;
        parBit    = (^data) ^ parTyp ^ badPar;
        n         = parEn ? 11 : 10;
        frameBits = '1;
        frameBits[0]   = 1'b0;
        frameBits[8:1] = data;
        if (parEn) begin
            frameBits[9]  = parBit;
            frameBits[10] = stopBit;
        end else begin
            frameBits[9] = stopBit;
        end
        perr = parEn && badPar;
        ferr = !stopBit;
        if (!perr && !ferr) lastGood = data;
        e.flags   = {!perr && !ferr, perr, ferr};
        e.data    = lastGood;
        e.edgeIdx = edgeCount + (n - 1) * bitLen + bitLen / 2 + 2;
        expQ.push_back(e);
        for (int i = 0; i < n; i++) begin
            RX_IN = frameBits[i];
            repeat (bitLen) @(negedge CLK);
            if (i == 0) begin
                Prescale = (code == 6'd16) ? 6'd32 : 6'd16;
                PAR_EN   = ~parEn;
                PAR_TYP  = ~parTyp;
            end
        end
        RX_IN = 1'b1;
        repeat (idleAfter) @(negedge CLK);
    endtask

    // Scoreboard side: every strobe cycle pops one expectation.
    always @(posedge CLK) begin
        expect_t e;
        #1;
        if (!RST && (data_valid || parity_error || framing_error)) begin
            if (expQ.size() == 0) begin
                checkOutput("spurious_strobe", {29'd0, data_valid, parity_error, framing_error}, 32'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("flags", {29'd0, data_valid, parity_error, framing_error}, {29'd0, e.flags});
                checkOutput("p_data", {24'd0, P_DATA}, {24'd0, e.data});
                checkOutput("strobe_edge", edgeCount - 1, e.edgeIdx);
            end
        end
    end

    initial begin
        int waitCycles;
        RST      = 1'b1;
        RX_IN    = 1'b1;
        Prescale = 6'd8;
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b0;
        repeat (3) @(negedge CLK);
        checkOutput("rst_p_data", {24'd0, P_DATA}, 32'd0);
        checkOutput("rst_data_valid", {31'd0, data_valid}, 32'd0);
        checkOutput("rst_parity_error", {31'd0, parity_error}, 32'd0);
        checkOutput("rst_framing_error", {31'd0, framing_error}, 32'd0);
        RST = 1'b0;
        repeat (4) @(negedge CLK);

        $display("[TB] P=8 clean frame");
        applyStimulus(8'hA5, 6'd8, 8, 0, 0, 0, 1, 6);

        $display("[TB] P=16 even parity good then bad");
        applyStimulus(8'h3C, 6'd16, 16, 1, 0, 0, 1, 10);
        applyStimulus(8'h3C, 6'd16, 16, 1, 0, 1, 1, 10);

        $display("[TB] P=8 stop bit low then clean frames");
        applyStimulus(8'h55, 6'd8, 8, 0, 0, 0, 0, 20);
        applyStimulus(8'h0F, 6'd8, 8, 0, 0, 0, 1, 6);
        applyStimulus(8'hC3, 6'd20, 8, 0, 0, 0, 1, 6);

        $display("[TB] P=16 short start glitch");
        Prescale = 6'd16;
        PAR_EN   = 1'b0;
        RX_IN    = 1'b0;
        repeat (3) @(negedge CLK);
        RX_IN = 1'b1;
        repeat (9) @(negedge CLK);
        applyStimulus(8'h81, 6'd16, 16, 0, 0, 0, 1, 10);

        $display("[TB] P=32 odd parity back-to-back");
        applyStimulus(8'h00, 6'd32, 32, 1, 1, 0, 1, 0);
        applyStimulus(8'hFF, 6'd32, 32, 1, 1, 0, 1, 0);
        applyStimulus(8'h7E, 6'd32, 32, 1, 1, 0, 1, 10);

        $display("[TB] reset during data bit 4");
        Prescale = 6'd8;
        PAR_EN   = 1'b0;
        RX_IN    = 1'b0;
        repeat (8) @(negedge CLK);
        for (int i = 0; i < 4; i++) begin
            RX_IN = (8'hAA >> i) & 8'h01;
            repeat (8) @(negedge CLK);
        end
        RX_IN = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        lastGood = 8'h00;
        repeat (2) @(negedge CLK);
        checkOutput("midframe_rst_p_data", {24'd0, P_DATA}, 32'd0);
        checkOutput("midframe_rst_valid", {31'd0, data_valid}, 32'd0);
        RST   = 1'b0;
        RX_IN = 1'b1;
        repeat (10) @(negedge CLK);
        checkOutput("post_rst_p_data", {24'd0, P_DATA}, 32'd0);
        applyStimulus(8'h11, 6'd8, 8, 0, 0, 0, 1, 6);

        waitCycles = 0;
        while (expQ.size() != 0 && waitCycles < 400) begin
            @(negedge CLK);
            waitCycles++;
        end
        checkOutput("queue_drained", expQ.size(), 32'd0);
        repeat (40) @(negedge CLK);
        checkOutput("final_p_data", {24'd0, P_DATA}, 32'h11);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
